// File: rtl/phy_tx_serializer_n_pkg.sv
// Shared constants and helpers for the PHY transmit serializer.
// Build option: define PHY_TX_PARITY_EN to append an even-parity bit to every frame.
package phy_tx_serializer_n_pkg;

  localparam logic [7:0] IDLE_CHAR_DEFAULT = 8'hBC;

`ifdef PHY_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  // Serial frame length: data bits plus the optional parity bit.
  function automatic int unsigned frame_w(input int unsigned data_w);
    return data_w + (PARITY_EN ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/phy_lane_fifo.sv
// Per-lane word FIFO with registered full/empty flags and asynchronous active-high reset.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module phy_lane_fifo
  import phy_tx_serializer_n_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; the flags guard every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/phy_tx_serializer_n.sv
// Single-clock PHY transmit serializer: round-robin lane FIFOs into one MSB-first bitstream.
// Build option: PHY_TX_PARITY_EN appends an even-parity bit after each word (IDLE included).
module phy_tx_serializer_n
  import phy_tx_serializer_n_pkg::*;
#(
  parameter int unsigned       NUM_LANES  = 4,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_CHAR  = DATA_W'(IDLE_CHAR_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          active,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [NUM_LANES-1:0]          in_valid,
  output logic [NUM_LANES-1:0]          in_ready,
  output logic                          serial_out,
  output logic                          word_start,
  output logic [clog2(NUM_LANES)-1:0]   cur_lane,
  output logic                          cur_valid,
  output logic [NUM_LANES*DATA_W-1:0]   recirc_data,
  output logic [NUM_LANES-1:0]          recirc_valid
);

  localparam int unsigned LANE_W  = clog2(NUM_LANES);
  localparam int unsigned FRAME_W = frame_w(DATA_W);
  localparam int unsigned CNT_W   = clog2(FRAME_W);

  logic [FRAME_W-1:0]  shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [LANE_W-1:0]   rr_ptr;
  logic [LANE_W-1:0]   sel_lane;
  logic                sel_found;
  logic                load;
  logic                do_pop;
  logic [DATA_W-1:0]   load_word;
  logic [NUM_LANES-1:0] fifo_full;
  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] pop;
  logic [DATA_W-1:0]   fifo_head [NUM_LANES];

  function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] word);
`ifdef PHY_TX_PARITY_EN
    return {word, ^word};
`else
    return word;
`endif
  endfunction

  function automatic logic [LANE_W-1:0] lane_at(input logic [LANE_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    return LANE_W'(s);
  endfunction

  // Lane FIFOs; pushes only while the link is up, otherwise input words recirculate.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign push[i]     = active & in_valid[i] & ~fifo_full[i];
    assign pop[i]      = do_pop & (sel_lane == LANE_W'(i));
    assign in_ready[i] = active ? ~fifo_full[i] : 1'b1;

    phy_lane_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head      (fifo_head[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  // First non-empty lane searching upward from rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = rr_ptr;
    for (int unsigned off = 0; off < NUM_LANES; off++) begin
      if (!sel_found && !fifo_empty[lane_at(rr_ptr, off)]) begin
        sel_found = 1'b1;
        sel_lane  = lane_at(rr_ptr, off);
      end
    end
  end

  assign load      = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign do_pop    = load & active & sel_found;
  assign load_word = do_pop ? fifo_head[sel_lane] : IDLE_CHAR;
  assign serial_out = shift_reg[FRAME_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= make_frame(IDLE_CHAR);
      bit_cnt    <= '0;
      word_start <= 1'b1;
      cur_lane   <= '0;
      cur_valid  <= 1'b0;
      rr_ptr     <= '0;
    end else if (load) begin
      shift_reg  <= make_frame(load_word);
      bit_cnt    <= '0;
      word_start <= 1'b1;
      cur_valid  <= do_pop;
      if (do_pop) begin
        cur_lane <= sel_lane;
        rr_ptr   <= (sel_lane == LANE_W'(NUM_LANES - 1)) ? '0 : sel_lane + LANE_W'(1);
      end
    end else begin
      shift_reg  <= {shift_reg[FRAME_W-2:0], 1'b0};
      bit_cnt    <= bit_cnt + CNT_W'(1);
      word_start <= 1'b0;
    end
  end

  // Recirculation path: words bypass the FIFOs while the link is down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recirc_data  <= '0;
      recirc_valid <= '0;
    end else if (!active) begin
      recirc_data  <= in_data;
      recirc_valid <= in_valid;
    end else begin
      recirc_valid <= '0;
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer_n.sv
// Self-checking bench for phy_tx_serializer_n: directed frame table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_phy_tx_serializer_n;

`ifdef PHY_TX_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif
  localparam int NL    = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        serial_out;
  logic        word_start;
  logic [1:0]  cur_lane;
  logic        cur_valid;
  logic [31:0] recirc_data;
  logic [3:0]  recirc_valid;

  phy_tx_serializer_n dut (
    .clk          (clk),
    .reset        (reset),
    .active       (active),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .word_start   (word_start),
    .cur_lane     (cur_lane),
    .cur_valid    (cur_valid),
    .recirc_data  (recirc_data),
    .recirc_valid (recirc_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-lane queues, frame being sent, position within it.
  logic [7:0]    m_q [NL][$];
  int            m_pos;
  int            m_rr;
  int            m_lane;
  logic          m_valid;
  logic [FW-1:0] m_frame;
  logic [31:0]   m_rdata;
  logic [3:0]    m_rvalid;

  logic [FW-1:0] cap = '0;
  logic [FW-1:0] got_f [$];
  int            got_l [$];
  logic          got_v [$];
  logic [3:0]    dmy;

  typedef struct {
    logic        act;
    logic [3:0]  vmask;
    logic [31:0] data;
    int          nfr;
    logic [31:0] words;
    logic [7:0]  lanes;
    logic [3:0]  valids;
  } vec_t;

  function automatic logic [FW-1:0] make_frame(input logic [7:0] w);
`ifdef PHY_TX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_q[i].delete();
    m_pos    = 0;
    m_rr     = 0;
    m_lane   = 0;
    m_valid  = 1'b0;
    m_frame  = make_frame(IDLE);
    m_rdata  = '0;
    m_rvalid = '0;
  endtask

  task automatic observe();
    chk("serial_out", 32'(serial_out), 32'(m_frame[FW-1-m_pos]));
    chk("word_start", 32'(word_start), 32'(m_pos == 0));
    chk("cur_valid", 32'(cur_valid), 32'(m_valid));
    chk("cur_lane", 32'(cur_lane), 32'(m_lane));
    chk("recirc_valid", 32'(recirc_valid), 32'(m_rvalid));
    chk("recirc_data", recirc_data, m_rdata);
    cap = {cap[FW-2:0], serial_out};
    if (m_pos == FW - 1) begin
      got_f.push_back(cap);
      got_l.push_back(int'(cur_lane));
      got_v.push_back(cur_valid);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, then observe outputs.
  task automatic step(input logic a, input logic [3:0] v, input logic [31:0] d,
                      output logic [3:0] acc_o);
    logic [3:0] exp_rdy;
    logic [3:0] acc;
    int sel;
    active   = a;
    in_valid = v;
    in_data  = d;
    #1;
    for (int i = 0; i < NL; i++) begin
      exp_rdy[i] = a ? (m_q[i].size() < DEPTH) : 1'b1;
      acc[i]     = a && v[i] && (m_q[i].size() < DEPTH);
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_pos == FW - 1) begin
      sel = -1;
      if (a) begin
        for (int k = 0; k < NL; k++) begin
          if (sel < 0 && m_q[(m_rr + k) % NL].size() > 0) sel = (m_rr + k) % NL;
        end
      end
      if (sel >= 0) begin
        m_frame = make_frame(m_q[sel].pop_front());
        m_lane  = sel;
        m_valid = 1'b1;
        m_rr    = (sel + 1) % NL;
      end else begin
        m_frame = make_frame(IDLE);
        m_valid = 1'b0;
      end
      m_pos = 0;
    end else begin
      m_pos++;
    end
    for (int i = 0; i < NL; i++) if (acc[i]) m_q[i].push_back(d[i*8 +: 8]);
    if (!a) begin
      m_rdata  = d;
      m_rvalid = v;
    end else begin
      m_rvalid = '0;
    end
    acc_o = acc;
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t vc;
    int   k;
    logic a;
    logic [3:0] v;

    vecs[0] = '{1'b0, 4'b0000, 32'h0000_0000, 2, 32'h0000_BCBC, 8'b00_00_00_00, 4'b0000};
    vecs[1] = '{1'b1, 4'b1111, 32'h1312_1110, 4, 32'h1312_1110, 8'b11_10_01_00, 4'b1111};
    vecs[2] = '{1'b1, 4'b1001, 32'h2300_0020, 2, 32'h0000_2320, 8'b00_00_11_00, 4'b0011};
    vecs[3] = '{1'b1, 4'b0100, 32'h00A5_0000, 2, 32'h0000_BCA5, 8'b00_00_10_10, 4'b0001};
    vecs[4] = '{1'b0, 4'b0010, 32'h0000_5500, 2, 32'h0000_BCBC, 8'b00_00_10_10, 4'b0000};

    reset    = 1'b1;
    active   = 1'b0;
    in_valid = '0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_serial_out", 32'(serial_out), 32'(1));
    chk("reset_word_start", 32'(word_start), 32'(1));
    chk("reset_cur_valid", 32'(cur_valid), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'hF);
    observe();
    reset = 1'b0;

    // Directed frame table: push once at a frame start, then collect the frames after it.
    for (int t = 0; t < 5; t++) begin
      vc = vecs[t];
      for (int n = 0; n < 2 * FW && m_pos != 0; n++) step(vc.act, 4'h0, 32'h0, dmy);
      step(vc.act, vc.vmask, vc.data, dmy);
      for (int n = 0; n < 2 * FW && m_pos != FW - 1; n++) step(vc.act, 4'h0, 32'h0, dmy);
      got_f.delete(); got_l.delete(); got_v.delete();
      for (int n = 0; n < 200 && got_f.size() < vc.nfr; n++) step(vc.act, 4'h0, 32'h0, dmy);
      chk("vec_frame_count", 32'(got_f.size()), 32'(vc.nfr));
      for (int j = 0; j < vc.nfr && j < got_f.size(); j++) begin
        chk($sformatf("vec%0d_frame%0d", t, j), 32'(got_f[j]), 32'(make_frame(vc.words[j*8 +: 8])));
        chk($sformatf("vec%0d_lane%0d", t, j), 32'(got_l[j]), 32'(vc.lanes[j*2 +: 2]));
        chk($sformatf("vec%0d_valid%0d", t, j), 32'(got_v[j]), 32'(vc.valids[j]));
      end
    end

    // Recirculation while inactive, then cleared once the link comes up.
    step(1'b0, 4'b1000, 32'h7E00_0000, dmy);
    chk("recirc_valid_inactive", 32'(recirc_valid), 32'h8);
    chk("recirc_data_lane3", 32'(recirc_data[31:24]), 32'h7E);
    chk("recirc_serial_idle", 32'(cur_valid), 32'(0));
    step(1'b1, 4'b0000, 32'h0, dmy);
    chk("recirc_valid_active", 32'(recirc_valid), 32'h0);
    chk("recirc_data_held", 32'(recirc_data[31:24]), 32'h7E);

    // Back-to-back pushes into lane 1 until its FIFO fills; the fifth word waits for a pop.
    for (int n = 0; n < 2 * FW && m_pos != 0; n++) step(1'b1, 4'h0, 32'h0, dmy);
    got_f.delete(); got_l.delete(); got_v.delete();
    k = 0;
    for (int n = 0; n < 100 && k < 5; n++) begin
      step(1'b1, 4'b0010, {16'h0, 8'(k + 1), 8'h00}, dmy);
      if (dmy[1]) begin
        k++;
        if (k == 4) chk("lane1_ready_when_full", 32'(in_ready[1]), 32'(0));
      end
    end
    chk("lane1_words_accepted", 32'(k), 32'(5));
    for (int n = 0; n < 200 && got_f.size() < 6; n++) step(1'b1, 4'h0, 32'h0, dmy);
    chk("lane1_frame_count", 32'(got_f.size()), 32'(6));
    for (int j = 1; j < 6 && j < got_f.size(); j++) begin
      chk($sformatf("lane1_frame%0d", j), 32'(got_f[j]), 32'(make_frame(8'(j))));
      chk($sformatf("lane1_lane%0d", j), 32'(got_l[j]), 32'(1));
    end

    // Randomized traffic with occasional link drops, checked every cycle by the model.
    a = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) a = ~a;
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(a, v, $urandom, dmy);
    end

    // Reset in the middle of a frame discards everything immediately.
    for (int n = 0; n < 2 * FW && m_pos != 3; n++) step(1'b1, 4'hF, $urandom, dmy);
    reset = 1'b1;
    #1;
    chk("midreset_serial_out", 32'(serial_out), 32'(1));
    chk("midreset_word_start", 32'(word_start), 32'(1));
    chk("midreset_cur_valid", 32'(cur_valid), 32'(0));
    chk("midreset_cur_lane", 32'(cur_lane), 32'(0));
    chk("midreset_recirc_valid", 32'(recirc_valid), 32'(0));
    chk("midreset_in_ready", 32'(in_ready), 32'hF);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    observe();
    for (int n = 0; n < 3 * FW; n++) step(1'b1, 4'h0, 32'h0, dmy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
